tdm_ser: RTL and testbench

TDM_SER -- requirements
Module: tdm_ser

---
 rtl/tdm_ser.sv | 135 +++++++++++++
 tb/tb_tdm_ser.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_ser.sv
// Purpose : frame-parallel to TDM-serial converter with a 2-deep frame buffer and underrun handling.
// Latency : one clk from a bit_en strobe to the registered fs/tdmout update.
// Backpress: ready drops while the frame buffer holds two frames; valid without ready is ignored.
//
// Ports:
//   clk, rstn         clock and synchronous active-low reset
//   enable            block enable; low clears the block on the next clk
//   bit_en            one strobe per TDM bit period
//   valid/ready/pdata frame handshake; slot c = pdata[c*WORD_W +: WORD_W]
//   fs, tdmout        registered frame sync and serial data
//   retransIncr       one-clk pulse per frame boundary that repeats the held frame
//   underrunIncr      one-clk pulse per frame boundary that found the buffer empty
module tdm_ser #(
  parameter int CHANNELS        = 8,
  parameter int WORD_W          = 32,
  parameter int MSB_FIRST       = 0,
  parameter int FS_LONG         = 0,
  parameter int REPEAT_UNDERRUN = 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         enable,
  input  logic                         bit_en,
  input  logic                         valid,
  output logic                         ready,
  input  logic [CHANNELS*WORD_W-1:0]   pdata,
  output logic                         fs,
  output logic                         tdmout,
  output logic                         retransIncr,
  output logic                         underrunIncr
);

  localparam int FRAME_BITS = CHANNELS * WORD_W;
  localparam int CW         = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int BW         = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]            state;
  logic [CW-1:0]         cnt;     // bit position within the frame
  logic [BW-1:0]         bpos;    // bit position within the current slot (cnt mod WORD_W)
  logic [1:0]            occ;     // frame buffer occupancy, 0..2
  logic [FRAME_BITS-1:0] ent0;    // buffer head
  logic [FRAME_BITS-1:0] ent1;
  logic [FRAME_BITS-1:0] frame;   // frame currently being shifted out

  logic                  push;
  logic                  pop;
  logic                  strobe;
  logic                  boundary;
  logic [FRAME_BITS-1:0] frame_nxt;
  logic [CW-1:0]         idx;

  // Depends on registered occupancy only, never on this cycle's pop.
  assign ready = rstn && enable && (occ != 2'd2);
  assign push  = valid && ready;

  // A strobe shifts a bit when already sending, or starts sending when a frame is waiting.
  // cnt is held at 0 in IDLE, so the start cycle is also a frame boundary.
  assign strobe   = bit_en && ((state == SEND) || (occ != 2'd0));
  assign boundary = strobe && (cnt == '0);
  assign pop      = boundary && (occ != 2'd0);

  // At a boundary the bit for index 0 must come from the frame being loaded now.
  always_comb begin
    frame_nxt = frame;
    if (boundary) begin
      if (pop) begin
        frame_nxt = ent0;
      end else if (REPEAT_UNDERRUN == 0) begin
        frame_nxt = '0;
      end
    end
  end

  // MSB-first mirrors the bit inside its slot: slot_base + (WORD_W-1-bpos) = cnt + WORD_W-1 - 2*bpos.
  always_comb begin
    idx = cnt;
    if (MSB_FIRST != 0) begin
      idx = cnt + CW'(WORD_W - 1) - (CW'(bpos) << 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || !enable) begin
      state        <= IDLE;
      cnt          <= '0;
      bpos         <= '0;
      occ          <= 2'd0;
      ent0         <= '0;
      ent1         <= '0;
      frame        <= '0;
      fs           <= 1'b0;
      tdmout       <= 1'b0;
      retransIncr  <= 1'b0;
      underrunIncr <= 1'b0;
    end else begin
      retransIncr  <= boundary && !pop && (REPEAT_UNDERRUN != 0);
      underrunIncr <= boundary && !pop;

      if (strobe) begin
        state  <= SEND;
        frame  <= frame_nxt;
        tdmout <= frame_nxt[idx];
        if (FS_LONG != 0) begin
          fs <= ({1'b0, cnt} < (CW+1)'(WORD_W));
        end else begin
          fs <= (cnt == '0);
        end
        cnt  <= (cnt == CW'(FRAME_BITS - 1)) ? '0 : cnt + CW'(1);
        bpos <= (bpos == BW'(WORD_W - 1)) ? '0 : bpos + BW'(1);
      end

      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            ent0 <= pdata;
          end else begin
            ent1 <= pdata;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          occ  <= occ - 2'd1;
        end
        // Push and pop together only happens at occupancy 1: the new frame becomes the head.
        2'b11: ent0 <= pdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_ser.sv
// Bench for tdm_ser: two instances (CHANNELS=2, WORD_W=4) sharing stimulus.
// u0: LSB first, one-bit fs, repeat on underrun. u1: MSB first, long fs, zeros on underrun.
module tb_tdm_ser;

  localparam int W  = 4;
  localparam int FB = 8;
  localparam bit [1:0] MSB_P = 2'b10;
  localparam bit [1:0] FSL_P = 2'b10;
  localparam bit [1:0] REP_P = 2'b01;

  logic       clk = 1'b0;
  logic       rstn, enable, bit_en, valid;
  logic [7:0] pdata;
  logic [1:0] ready_o, fs_o, tdm_o, ret_o, und_o;

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  tdm_ser #(.CHANNELS(2), .WORD_W(4), .MSB_FIRST(0), .FS_LONG(0), .REPEAT_UNDERRUN(1)) u0 (
    .clk(clk), .rstn(rstn), .enable(enable), .bit_en(bit_en), .valid(valid),
    .ready(ready_o[0]), .pdata(pdata), .fs(fs_o[0]), .tdmout(tdm_o[0]),
    .retransIncr(ret_o[0]), .underrunIncr(und_o[0]));

  tdm_ser #(.CHANNELS(2), .WORD_W(4), .MSB_FIRST(1), .FS_LONG(1), .REPEAT_UNDERRUN(0)) u1 (
    .clk(clk), .rstn(rstn), .enable(enable), .bit_en(bit_en), .valid(valid),
    .ready(ready_o[1]), .pdata(pdata), .fs(fs_o[1]), .tdmout(tdm_o[1]),
    .retransIncr(ret_o[1]), .underrunIncr(und_o[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a frame queue, the frame on the wire and a bit position.
  logic [7:0] m_q [2][2];
  int         m_cnt [2];
  bit         m_act [2];
  int         m_pos [2];
  logic [7:0] m_cur [2];
  logic       m_fs [2], m_tdm [2], m_ret [2], m_und [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_act[i] = 0; m_pos[i] = 0; m_cur[i] = '0;
      m_fs[i] = 0; m_tdm[i] = 0; m_ret[i] = 0; m_und[i] = 0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        bit         psh;
        int         slot, b;
        logic [7:0] fr;
        m_ret[i] = 0;
        m_und[i] = 0;
        if (!rstn || !enable) begin
          m_cnt[i] = 0; m_act[i] = 0; m_pos[i] = 0; m_cur[i] = '0;
          m_fs[i] = 0; m_tdm[i] = 0;
        end else begin
          psh = valid && (m_cnt[i] < 2);
          if (bit_en && (m_act[i] ? (m_pos[i] == 0) : (m_cnt[i] > 0))) begin
            if (m_cnt[i] > 0) begin
              m_cur[i] = m_q[i][0];
              m_q[i][0] = m_q[i][1];
              m_cnt[i]--;
            end else if (REP_P[i]) begin
              m_ret[i] = 1;
              m_und[i] = 1;
            end else begin
              m_cur[i] = '0;
              m_und[i] = 1;
            end
            m_act[i] = 1;
          end
          if (bit_en && m_act[i]) begin
            slot = m_pos[i] / W;
            b    = m_pos[i] % W;
            fr   = m_cur[i];
            m_tdm[i] = fr[slot*W + (MSB_P[i] ? (W-1-b) : b)];
            m_fs[i]  = FSL_P[i] ? (m_pos[i] < W) : (m_pos[i] == 0);
            m_pos[i] = (m_pos[i] + 1) % FB;
          end
          if (psh) begin
            m_q[i][m_cnt[i]] = pdata;
            m_cnt[i]++;
          end
        end
      end
    end
  end

  // Compare every output of both instances against the model each cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int i = 0; i < 2; i++) begin
          check($sformatf("ready%0d", i), 32'(ready_o[i]), 32'(rstn && enable && (m_cnt[i] < 2)));
          check($sformatf("fs%0d", i),    32'(fs_o[i]),    32'(m_fs[i]));
          check($sformatf("tdm%0d", i),   32'(tdm_o[i]),   32'(m_tdm[i]));
          check($sformatf("retr%0d", i),  32'(ret_o[i]),   32'(m_ret[i]));
          check($sformatf("undr%0d", i),  32'(und_o[i]),   32'(m_und[i]));
        end
      end
    end
  end

  logic [7:0]  s0, s1, f0, f1;
  logic [31:0] stream, fsvec;
  logic        cap [48];
  logic        capfs [48];
  logic [7:0]  vals [5];
  int          r0, u0c, r1, u1c, k, first;
  bit          saw_low, acc;

  initial begin
    rstn = 0; enable = 1; valid = 0; bit_en = 1; pdata = '0;
    step();
    mon_en = 1;
    repeat (2) step();
    check("rst_ready", 32'(ready_o), 0);
    check("rst_fs_tdm", {30'd0, fs_o | tdm_o}, 0);

    rstn = 1;
    #1;
    check("ready_after_rst", 32'(ready_o), 32'h3);

    // Single frame A5, then underrun behaviour over the following frame.
    valid = 1; pdata = 8'hA5; step(); valid = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      s0[i] = tdm_o[0]; f0[i] = fs_o[0]; s1[i] = tdm_o[1]; f1[i] = fs_o[1];
    end
    check("a5_lsb_seq", 32'(s0), 32'hA5);
    check("a5_lsb_fs",  32'(f0), 32'h01);
    check("a5_msb_seq", 32'(s1), 32'h5A);
    check("a5_long_fs", 32'(f1), 32'h0F);
    r0 = 0; u0c = 0; r1 = 0; u1c = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      s0[i] = tdm_o[0]; s1[i] = tdm_o[1];
      r0 += int'(ret_o[0]); u0c += int'(und_o[0]);
      r1 += int'(ret_o[1]); u1c += int'(und_o[1]);
    end
    check("repeat_seq", 32'(s0), 32'hA5);
    check("zero_seq",   32'(s1), 32'h00);
    check("repeat_pulses", {r0[15:0], u0c[15:0]}, 32'h0001_0001);
    check("zero_pulses",   {r1[15:0], u1c[15:0]}, 32'h0000_0001);

    // Reset at cnt = 3 aborts the frame.
    repeat (3) step();
    rstn = 0; step();
    check("midrst_out", {28'd0, fs_o, tdm_o}, 0);
    rstn = 1; step();

    // Enable low at cnt = 3, then the next frame starts with fs.
    valid = 1; pdata = 8'h3C; step(); valid = 0;
    repeat (3) step();
    enable = 0; step();
    check("dis_out", {24'd0, fs_o, tdm_o, ret_o, und_o}, 0);
    check("dis_ready", 32'(ready_o), 0);
    enable = 1;
    #1;
    check("reen_ready", 32'(ready_o), 32'h3);
    valid = 1; pdata = 8'h81; step(); valid = 0; step();
    check("reen_fs", 32'(fs_o), 32'h3);
    check("reen_bit0", 32'(tdm_o), 32'h1);
    repeat (7) step();

    // Held valid, back-to-back frames, buffer full backpressure.
    enable = 0; step(); enable = 1;
    vals[0] = 8'h01; vals[1] = 8'h02; vals[2] = 8'h03; vals[3] = 8'h04; vals[4] = 8'h00;
    k = 0; saw_low = 0;
    for (int c = 0; c < 48; c++) begin
      valid = (k < 4);
      pdata = vals[k];
      #1;
      if (!ready_o[0]) saw_low = 1;
      acc = valid && ready_o[0];
      step();
      if (acc) k++;
      cap[c] = tdm_o[0];
      capfs[c] = fs_o[0];
    end
    valid = 0;
    first = -1;
    for (int c = 47; c >= 0; c--) if (capfs[c]) first = c;
    check("b2b_first", 32'(first), 32'd1);
    if (first < 0) first = 0;
    for (int j = 0; j < 32; j++) begin
      stream[j] = (first + j < 48) ? cap[first+j] : 1'b0;
      fsvec[j]  = (first + j < 48) ? capfs[first+j] : 1'b0;
    end
    check("b2b_stream", stream, 32'h0403_0201);
    check("b2b_fs", fsvec, 32'h0101_0101);
    check("b2b_accepted", 32'(k), 32'd4);
    check("b2b_ready_low", 32'(saw_low), 32'd1);

    // Bit strobe every 4th clk.
    enable = 0; step(); enable = 1;
    bit_en = 0; valid = 1; pdata = 8'hA5; step(); valid = 0;
    for (int i = 0; i < 8; i++) begin
      bit_en = 1; step();
      s0[i] = tdm_o[0]; s1[i] = tdm_o[1];
      bit_en = 0; repeat (3) step();
    end
    check("slow_lsb_seq", 32'(s0), 32'hA5);
    check("slow_msb_seq", 32'(s1), 32'h5A);

    // Randomized traffic, strobes, resets and disables.
    for (int c = 0; c < 3000; c++) begin
      rstn   = ($urandom_range(0, 299) != 0);
      enable = ($urandom_range(0, 149) != 0);
      valid  = ($urandom_range(0, 2) == 0);
      pdata  = 8'($urandom);
      bit_en = ($urandom_range(0, 3) != 0);
      step();
    end

    rstn = 1; enable = 1; valid = 0; bit_en = 0;
    step();
    @(negedge clk);
    mon_en = 0;
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
